// File: rtl/set_assoc.sv
// One set of an N-way set-associative cache: per-way tag/valid/dirty/data plus true-LRU ages,
// served through a registered enable/ack handshake (IDLE -> LOOKUP -> RESP).
module set_assoc #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned WORD_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              comp,
  input  logic              write,
  input  logic [WORD_W-1:0] word,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [WAY_W-1:0]  way_in,
  output logic              hit,
  output logic              dirty_out,
  output logic              valid_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic [WAY_W-1:0]  way_out,
  output logic              ack,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e state_q, state_d;

  logic              req_comp_q, req_write_q, req_valid_q;
  logic [WORD_W-1:0] req_word_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [DATA_W-1:0] req_data_q;
  logic [WAY_W-1:0]  req_way_q;

  logic [TAG_W-1:0]  tag_q  [WAYS];
  logic [DATA_W-1:0] data_q [WAYS][WORDS];
  logic [WAY_W-1:0]  age_q  [WAYS];
  logic [WAYS-1:0]   valid_q, dirty_q;

  logic commit_wr_q, commit_touch_q;

  logic [WAYS-1:0]  match;
  logic             hit_any, lk_wr, lk_touch;
  logic [WAY_W-1:0] hit_way, victim_way, rep_way;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StLookup;
      StLookup: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ack  = (state_q == StResp);
    busy = (state_q != StIdle);
  end

  // Lookup: lowest matching way wins; victim is the way holding the oldest age.
  always_comb begin
    hit_way    = '0;
    victim_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      match[i] = valid_q[i] && (tag_q[i] == req_tag_q);
    end
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (match[i]) hit_way = WAY_W'(i);
    end
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (age_q[i] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(i);
    end
    hit_any  = |match;
    rep_way  = req_comp_q ? (hit_any ? hit_way : victim_way) : req_way_q;
    lk_wr    = req_write_q && (!req_comp_q || hit_any);
    lk_touch = req_comp_q ? hit_any : req_write_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_comp_q     <= 1'b0;
      req_write_q    <= 1'b0;
      req_valid_q    <= 1'b0;
      req_word_q     <= '0;
      req_tag_q      <= '0;
      req_data_q     <= '0;
      req_way_q      <= '0;
      hit            <= 1'b0;
      dirty_out      <= 1'b0;
      valid_out      <= 1'b0;
      tag_out        <= '0;
      data_out       <= '0;
      way_out        <= '0;
      commit_wr_q    <= 1'b0;
      commit_touch_q <= 1'b0;
      valid_q        <= '0;
      dirty_q        <= '0;
      for (int unsigned i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(i);
    end else begin
      if (state_q == StIdle && enable) begin
        req_comp_q  <= comp;
        req_write_q <= write;
        req_valid_q <= valid_in;
        req_word_q  <= word;
        req_tag_q   <= tag_in;
        req_data_q  <= data_in;
        req_way_q   <= way_in;
      end
      if (state_q == StLookup) begin
        hit            <= req_comp_q && hit_any;
        dirty_out      <= dirty_q[rep_way];
        valid_out      <= valid_q[rep_way];
        tag_out        <= tag_q[rep_way];
        data_out       <= data_q[rep_way][req_word_q];
        way_out        <= rep_way;
        commit_wr_q    <= lk_wr;
        commit_touch_q <= lk_touch;
      end
      // The committed way is always the reported way, so way_out doubles as the write index.
      if (state_q == StResp) begin
        if (commit_wr_q) begin
          if (req_comp_q) begin
            dirty_q[way_out] <= 1'b1;
          end else begin
            dirty_q[way_out] <= 1'b0;
            valid_q[way_out] <= req_valid_q;
          end
        end
        if (commit_touch_q) begin
          for (int unsigned j = 0; j < WAYS; j++) begin
            if (WAY_W'(j) == way_out)            age_q[j] <= '0;
            else if (age_q[j] < age_q[way_out]) age_q[j] <= age_q[j] + 1'b1;
          end
        end
      end
    end
  end

  // Tags and data are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (state_q == StResp && commit_wr_q) begin
      data_q[way_out][req_word_q] <= req_data_q;
      if (!req_comp_q) tag_q[way_out] <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_set_assoc.sv
// Randomised and directed bench for set_assoc against a queue-based LRU reference model.
module tb_set_assoc;

  localparam int WAYS = 4;
  localparam int WORDS = 4;

  logic        clk, rst, enable, comp, write, valid_in;
  logic [1:0]  word, way_in;
  logic [4:0]  tag_in;
  logic [15:0] data_in;
  logic        hit, dirty_out, valid_out, ack, busy;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic [1:0]  way_out;

  int tests = 0;
  int fails = 0;

  // Reference state; lru[0] is most recent, lru[$] is the victim.
  bit          m_valid [WAYS];
  bit          m_dirty [WAYS];
  logic [4:0]  m_tag   [WAYS];
  bit          m_tag_k [WAYS];
  logic [15:0] m_data  [WAYS][WORDS];
  bit          m_data_k[WAYS][WORDS];
  int          lru[$];

  set_assoc dut (
    .clk(clk), .rst(rst), .enable(enable), .comp(comp), .write(write), .word(word),
    .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in), .way_in(way_in),
    .hit(hit), .dirty_out(dirty_out), .valid_out(valid_out), .tag_out(tag_out),
    .data_out(data_out), .way_out(way_out), .ack(ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < WAYS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    lru = {0, 1, 2, 3};
  endfunction

  function automatic void touch(input int w);
    for (int k = 0; k < lru.size(); k++) begin
      if (lru[k] == w) begin
        lru.delete(k);
        break;
      end
    end
    lru.push_front(w);
  endfunction

  // Issue one request from an idle negedge; returns at a negedge with the DUT idle again.
  task automatic req(input string name, input bit c, input bit w, input int wd,
                     input logic [4:0] t, input logic [15:0] d, input bit v, input int wy);
    int  mw, e_way, n;
    bit  e_hit;
    mw = -1;
    for (int i = 0; i < WAYS; i++)
      if (mw < 0 && m_valid[i] && m_tag[i] == t) mw = i;
    if (c) begin
      e_hit = (mw >= 0);
      e_way = e_hit ? mw : lru[WAYS-1];
    end else begin
      e_hit = 1'b0;
      e_way = wy;
    end

    enable = 1'b1; comp = c; write = w; word = 2'(wd); tag_in = t;
    data_in = d; valid_in = v; way_in = 2'(wy);
    @(posedge clk);
    #1;
    enable = 1'b0; comp = 1'($urandom); write = 1'($urandom); word = 2'($urandom);
    tag_in = 5'($urandom); data_in = 16'($urandom); valid_in = 1'($urandom);
    way_in = 2'($urandom);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 6);
    check({name, ".latency"}, n, 2);
    check({name, ".busy"}, busy, 1);
    check({name, ".hit"}, hit, e_hit);
    check({name, ".way"}, way_out, e_way);
    check({name, ".valid"}, valid_out, m_valid[e_way]);
    check({name, ".dirty"}, dirty_out, m_dirty[e_way]);
    if (m_tag_k[e_way]) check({name, ".tag"}, tag_out, m_tag[e_way]);
    if (m_data_k[e_way][wd]) check({name, ".data"}, data_out, m_data[e_way][wd]);
    @(negedge clk);
    check({name, ".ack_pulse"}, ack, 0);
    check({name, ".hold"}, way_out, e_way);

    if (c && e_hit) begin
      if (w) begin
        m_data[e_way][wd] = d;
        m_data_k[e_way][wd] = 1'b1;
        m_dirty[e_way] = 1'b1;
      end
      touch(e_way);
    end else if (!c && w) begin
      m_tag[e_way] = t;
      m_tag_k[e_way] = 1'b1;
      m_valid[e_way] = v;
      m_dirty[e_way] = 1'b0;
      m_data[e_way][wd] = d;
      m_data_k[e_way][wd] = 1'b1;
      touch(e_way);
    end
  endtask

  initial begin
    for (int i = 0; i < WAYS; i++) begin
      m_tag_k[i] = 1'b0;
      for (int j = 0; j < WORDS; j++) m_data_k[i][j] = 1'b0;
    end
    model_reset();
    rst = 1'b0; enable = 1'b0; comp = 1'b0; write = 1'b0; word = '0;
    tag_in = '0; data_in = '0; valid_in = 1'b0; way_in = '0;
    repeat (3) @(negedge clk);
    check("reset.ack", ack, 0);
    check("reset.busy", busy, 0);
    check("reset.hit", hit, 0);
    check("reset.data", data_out, 0);
    rst = 1'b1;
    @(negedge clk);

    req("cold_miss", 1, 0, 0, 5'h03, 16'h0, 0, 0);
    check("cold_miss.victim3", way_out, 3);

    req("aw_way2", 0, 1, 1, 5'h0A, 16'hBEEF, 1, 2);
    req("cr_hit", 1, 0, 1, 5'h0A, 16'h0, 0, 0);
    check("cr_hit.beef", data_out, 16'hBEEF);
    req("cw_hit", 1, 1, 1, 5'h0A, 16'h1234, 0, 0);
    req("cr_after_cw", 1, 0, 1, 5'h0A, 16'h0, 0, 0);
    check("cr_after_cw.data", data_out, 16'h1234);
    check("cr_after_cw.dirty", dirty_out, 1);

    for (int i = 0; i < WAYS; i++)
      req("fill", 0, 1, 0, 5'(5'h10 + i), 16'(16'hA000 + i), 1, i);
    req("hit_way0", 1, 0, 0, 5'h10, 16'h0, 0, 0);
    req("miss_lru", 1, 0, 0, 5'h1F, 16'h0, 0, 0);
    check("miss_lru.way1", way_out, 1);
    check("miss_lru.tag", tag_out, 5'h11);

    req("aw_invalid", 0, 1, 1, 5'h0A, 16'h5555, 0, 2);
    req("cr_invalid", 1, 0, 1, 5'h0A, 16'h0, 0, 0);
    req("cw_invalid", 1, 1, 1, 5'h0A, 16'h7777, 0, 0);
    req("ar_unchanged", 0, 0, 1, 5'h00, 16'h0, 0, 2);
    check("ar_unchanged.data", data_out, 16'h5555);

    // Abort an access write while it sits in LOOKUP.
    enable = 1'b1; comp = 1'b0; write = 1'b1; word = 2'd0; tag_in = 5'h07;
    data_in = 16'hDEAD; valid_in = 1'b1; way_in = 2'd1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    rst = 1'b0;
    #1;
    check("abort.ack", ack, 0);
    check("abort.busy", busy, 0);
    check("abort.hit", hit, 0);
    check("abort.way", way_out, 0);
    check("abort.tag", tag_out, 0);
    check("abort.data", data_out, 0);
    repeat (2) @(negedge clk);
    check("abort.ack_later", ack, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    req("after_abort", 1, 0, 0, 5'h07, 16'h0, 0, 0);

    for (int k = 0; k < 200; k++) begin
      req("rand", 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
          5'($urandom_range(0, 5)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
